// File: rtl/calc_pkg.sv
// Shared constants for the calculator button front end: button indices and
// debounce FSM state encodings.
package calc_pkg;

  localparam int BTN_B1 = 0;
  localparam int BTN_B2 = 1;
  localparam int BTN_EQ = 2;
  localparam int BTN_OP = 3;

  localparam logic [1:0] ST_IDLE         = 2'd0;
  localparam logic [1:0] ST_PRESS_WAIT   = 2'd1;
  localparam logic [1:0] ST_HELD         = 2'd2;
  localparam logic [1:0] ST_RELEASE_WAIT = 2'd3;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/calc_btn_debounce.sv
// One push button: 2-flop synchronizer, debounce FSM and counters.
// Auto-repeat while held is built only when CALC_BTN_AUTOREPEAT_EN is defined.
module calc_btn_debounce
  import calc_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 8,
  parameter int REPEAT_DELAY    = 64,
  parameter int REPEAT_PERIOD   = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       raw,
  output logic       level,
  output logic       press,
  output logic       rel,
  output logic [1:0] state
);

  // The counter never needs to count past the largest configured interval.
  localparam int               CNT_NEED = max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
  localparam logic [CNT_W-1:0] CNT_LIM  = CNT_W'(CNT_NEED);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic [1:0]       st;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic             cnt_done;
  logic             repeat_hit;

  assign cnt_inc  = (cnt >= CNT_LIM) ? cnt : cnt + 1'b1;
  assign cnt_done = (cnt == DEB_LAST);
  assign state    = st;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st    <= ST_IDLE;
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
      rel   <= 1'b0;
    end else begin
      press <= 1'b0;
      rel   <= 1'b0;
      case (st)
        ST_IDLE: begin
          if (sync2) begin
            st  <= ST_PRESS_WAIT;
            cnt <= CNT_ONE;
          end
        end
        ST_PRESS_WAIT: begin
          if (!sync2) begin
            st  <= ST_IDLE;
            cnt <= '0;
          end else if (cnt_done) begin
            st    <= ST_HELD;
            cnt   <= '0;
            level <= 1'b1;
            press <= 1'b1;
          end else begin
            cnt <= cnt_inc;
          end
        end
        ST_HELD: begin
          if (!sync2) begin
            st  <= ST_RELEASE_WAIT;
            cnt <= CNT_ONE;
          end else begin
            press <= repeat_hit;
          end
        end
        ST_RELEASE_WAIT: begin
          // A bounce back to pressed returns to HELD silently; level never dropped.
          if (sync2) begin
            st  <= ST_HELD;
            cnt <= '0;
          end else if (cnt_done) begin
            st    <= ST_IDLE;
            cnt   <= '0;
            level <= 1'b0;
            rel   <= 1'b1;
          end else begin
            cnt <= cnt_inc;
          end
        end
        default: begin
          st  <= ST_IDLE;
          cnt <= '0;
        end
      endcase
    end
  end

`ifdef CALC_BTN_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] RPT_LAST   = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RPT_RELOAD = CNT_W'(REPEAT_DELAY - REPEAT_PERIOD);

  logic [CNT_W-1:0] hold;

  assign repeat_hit = (hold == RPT_LAST);

  // Frozen in RELEASE_WAIT so a bounce back to HELD resumes the cadence.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold <= '0;
    end else if (st == ST_HELD && sync2) begin
      hold <= repeat_hit ? RPT_RELOAD : hold + 1'b1;
    end else if (st == ST_RELEASE_WAIT && !sync2 && cnt_done) begin
      hold <= '0;
    end
  end
`else
  assign repeat_hit = 1'b0;
`endif

endmodule

// File: rtl/calc_button_conditioner.sv
// Calculator button front end: one debouncer per button plus any_press.
// Optional auto-repeat is enabled by defining CALC_BTN_AUTOREPEAT_EN.
module calc_button_conditioner #(
  parameter int N_BTN           = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 8,
  parameter int REPEAT_DELAY    = 64,
  parameter int REPEAT_PERIOD   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_BTN-1:0]   btn_raw,
  output logic [N_BTN-1:0]   btn_level,
  output logic [N_BTN-1:0]   btn_press,
  output logic [N_BTN-1:0]   btn_release,
  output logic               any_press,
  output logic [2*N_BTN-1:0] dbg_state
);

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    calc_btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_db (
      .clk  (clk),
      .rst  (rst),
      .raw  (btn_raw[i]),
      .level(btn_level[i]),
      .press(btn_press[i]),
      .rel  (btn_release[i]),
      .state(dbg_state[2*i +: 2])
    );
  end

  assign any_press = |btn_press;

endmodule

// File: tb/tb_calc_button_conditioner.sv
// Bench for calc_button_conditioner with short debounce/repeat timing and a
// behavioural run-length model of the debounce rules.
module tb_calc_button_conditioner;
  import calc_pkg::*;

  localparam int N   = 4;
  localparam int DEB = 4;
  localparam int CW  = 8;
  localparam int RD  = 8;
  localparam int RP  = 4;
  localparam int W   = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   btn_raw;
  logic [N-1:0]   btn_level;
  logic [N-1:0]   btn_press;
  logic [N-1:0]   btn_release;
  logic           any_press;
  logic [2*N-1:0] dbg_state;

  int n_chk = 0;
  int n_err = 0;

  // Model: raw delayed two samples, then a change is accepted after DEB
  // consecutive samples that disagree with the current level.
  logic [N-1:0] m_d1, m_d2, m_level, m_press, m_release;
  int           m_run [N];
  int           m_hold[N];
  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_q[$];

  calc_button_conditioner #(
    .N_BTN(N), .DEBOUNCE_CYCLES(DEB), .CNT_W(CW), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk), .rst(rst), .btn_raw(btn_raw), .btn_level(btn_level), .btn_press(btn_press),
    .btn_release(btn_release), .any_press(any_press), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_d1 = '0; m_d2 = '0; m_level = '0; m_press = '0; m_release = '0;
    for (int i = 0; i < N; i++) begin
      m_run[i] = 0;
      m_hold[i] = 0;
    end
  endtask

  task automatic model_update();
    logic [N-1:0] seen;
    seen = m_d2;
    m_d2 = m_d1;
    m_d1 = btn_raw;
    m_press = '0;
    m_release = '0;
    for (int i = 0; i < N; i++) begin
      if (seen[i] !== m_level[i]) begin
        m_run[i]++;
        if (m_run[i] == DEB) begin
          m_level[i] = seen[i];
          m_run[i] = 0;
          m_hold[i] = 0;
          if (seen[i]) m_press[i] = 1'b1;
          else m_release[i] = 1'b1;
        end
      end else begin
        if (m_level[i] && m_run[i] == 0) begin
          m_hold[i]++;
`ifdef CALC_BTN_AUTOREPEAT_EN
          if (m_hold[i] >= RD && (m_hold[i] - RD) % RP == 0) m_press[i] = 1'b1;
`endif
        end
        m_run[i] = 0;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (rst) model_reset();
    else model_update();
    @(negedge clk);
  endtask

  task automatic settle();
    btn_raw = '0;
    for (int e = 1; e <= 12; e++) begin
      step();
      n_chk++;
      if ({btn_level, btn_press, btn_release, any_press} !== {m_level, m_press, m_release, |m_press}) begin
        n_err++;
        $display("FAIL settle e=%0d got=%h exp=%h", e, {btn_level, btn_press, btn_release, any_press},
                 {m_level, m_press, m_release, |m_press});
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    btn_raw = '1;
    model_reset();
    for (int c = 0; c < 3; c++) begin
      step();
      n_chk++;
      if ({btn_level, btn_press, btn_release, any_press, dbg_state} !== '0) begin
        n_err++;
        $display("FAIL reset_outputs c=%0d got=%h exp=0", c,
                 {btn_level, btn_press, btn_release, any_press, dbg_state});
      end
    end
    rst = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      step();
      n_chk++;
      if (btn_press !== ((e == 6) ? 4'hF : 4'h0)) begin
        n_err++;
        $display("FAIL reset_first_press e=%0d got=%h exp=%h", e, btn_press, (e == 6) ? 4'hF : 4'h0);
      end
      n_chk++;
      if ({btn_level, btn_press, btn_release, any_press} !== {m_level, m_press, m_release, |m_press}) begin
        n_err++;
        $display("FAIL reset_model e=%0d got=%h exp=%h", e, {btn_level, btn_press, btn_release, any_press},
                 {m_level, m_press, m_release, |m_press});
      end
    end
    settle();
  endtask

  task automatic test_glitch();
    int presses = 0;
    btn_raw[BTN_B1] = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      if (e == 3) btn_raw[BTN_B1] = 1'b0;
      step();
      if (btn_press[BTN_B1]) presses++;
      n_chk++;
      if (btn_level[BTN_B1] !== 1'b0) begin
        n_err++;
        $display("FAIL glitch_level e=%0d got=%b exp=0", e, btn_level[BTN_B1]);
      end
    end
    n_chk++;
    if (presses != 0) begin
      n_err++;
      $display("FAIL glitch_press got=%0d exp=0", presses);
    end
    settle();
  endtask

  task automatic test_steady();
    int first_press = 0;
    int rel_edge = 0;
    int rel_cnt = 0;
    btn_raw[BTN_B2] = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      step();
      if (btn_press[BTN_B2] && first_press == 0) first_press = e;
      n_chk++;
      if ({btn_level, btn_press, btn_release, any_press} !== {m_level, m_press, m_release, |m_press}) begin
        n_err++;
        $display("FAIL steady_model e=%0d got=%h exp=%h", e, {btn_level, btn_press, btn_release, any_press},
                 {m_level, m_press, m_release, |m_press});
      end
    end
    n_chk++;
    if (first_press != DEB + 2 || btn_level[BTN_B2] !== 1'b1) begin
      n_err++;
      $display("FAIL steady_press edge got=%0d level=%b exp edge=%0d level=1", first_press,
               btn_level[BTN_B2], DEB + 2);
    end
    btn_raw[BTN_B2] = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      step();
      if (btn_release[BTN_B2]) begin
        rel_cnt++;
        rel_edge = e;
      end
    end
    n_chk++;
    if (rel_cnt != 1 || rel_edge != DEB + 2 || btn_level[BTN_B2] !== 1'b0) begin
      n_err++;
      $display("FAIL steady_release count=%0d edge=%0d level=%b exp count=1 edge=%0d level=0", rel_cnt,
               rel_edge, btn_level[BTN_B2], DEB + 2);
    end
    settle();
  endtask

  task automatic test_bounce();
    logic [4:0] pat = 5'b10101;
    int presses = 0;
    int edge_at = 0;
    for (int k = 0; k < 5; k++) begin
      btn_raw[BTN_EQ] = pat[k];
      step();
      if (btn_press[BTN_EQ]) presses++;
    end
    for (int e = 2; e <= 10; e++) begin
      step();
      if (btn_press[BTN_EQ]) begin
        presses++;
        edge_at = e;
      end
      n_chk++;
      if ({btn_level, btn_press, btn_release, any_press} !== {m_level, m_press, m_release, |m_press}) begin
        n_err++;
        $display("FAIL bounce_model e=%0d got=%h exp=%h", e, {btn_level, btn_press, btn_release, any_press},
                 {m_level, m_press, m_release, |m_press});
      end
    end
    n_chk++;
    if (presses != 1 || edge_at != DEB + 2) begin
      n_err++;
      $display("FAIL bounce_press count=%0d edge=%0d exp count=1 edge=%0d", presses, edge_at, DEB + 2);
    end
    settle();
  endtask

  task automatic test_simultaneous();
    btn_raw = 4'b1001;
    for (int e = 1; e <= 9; e++) begin
      step();
      n_chk++;
      if ({btn_press, any_press} !== ((e == 6) ? 5'b1001_1 : 5'b0000_0)) begin
        n_err++;
        $display("FAIL simul_press e=%0d got=%b exp=%b", e, {btn_press, any_press},
                 (e == 6) ? 5'b1001_1 : 5'b0000_0);
      end
    end
    settle();
  endtask

  task automatic test_autorepeat();
    exp_q.delete();
    got_q.delete();
    exp_q.push_back(W'(6));
`ifdef CALC_BTN_AUTOREPEAT_EN
    exp_q.push_back(W'(14));
    for (int t = 18; t <= 30; t += RP) exp_q.push_back(W'(t));
`endif
    btn_raw[BTN_B1] = 1'b1;
    for (int e = 1; e <= 30; e++) begin
      step();
      if (btn_press[BTN_B1]) got_q.push_back(W'(e));
      n_chk++;
      if ((btn_press & btn_release) !== '0) begin
        n_err++;
        $display("FAIL repeat_overlap e=%0d got=%h exp=0", e, btn_press & btn_release);
      end
    end
    n_chk++;
    if (got_q.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL repeat_count got=%0d exp=%0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_chk++;
      if (got_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL repeat_edge i=%0d got=%0d exp=%0d", i, got_q[i], exp_q[i]);
      end
    end
    settle();
  endtask

  task automatic test_reset_mid();
    int presses = 0;
    btn_raw[BTN_OP] = 1'b1;
    for (int e = 1; e <= 8; e++) step();
    rst = 1'b1;
    model_reset();
    #1;
    n_chk++;
    if ({btn_level, btn_press, btn_release, any_press} !== '0) begin
      n_err++;
      $display("FAIL reset_mid_async got=%h exp=0", {btn_level, btn_press, btn_release, any_press});
    end
    step();
    step();
    rst = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      step();
      if (btn_press[BTN_OP]) begin
        presses++;
        n_chk++;
        if (e != DEB + 2) begin
          n_err++;
          $display("FAIL reset_mid_edge got=%0d exp=%0d", e, DEB + 2);
        end
      end
    end
    n_chk++;
    if (presses != 1) begin
      n_err++;
      $display("FAIL reset_mid_press got=%0d exp=1", presses);
    end
    settle();
  endtask

  task automatic test_random();
    int left[N];
    for (int i = 0; i < N; i++) left[i] = $urandom_range(1, 14);
    for (int c = 0; c < 500; c++) begin
      for (int i = 0; i < N; i++) begin
        left[i]--;
        if (left[i] == 0) begin
          btn_raw[i] = ~btn_raw[i];
          left[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(4, 24);
        end
      end
      step();
      n_chk++;
      if ({btn_level, btn_press, btn_release, any_press} !== {m_level, m_press, m_release, |m_press}) begin
        n_err++;
        $display("FAIL random_model c=%0d got=%h exp=%h", c, {btn_level, btn_press, btn_release, any_press},
                 {m_level, m_press, m_release, |m_press});
      end
      n_chk++;
      if ((btn_press & btn_release) !== '0) begin
        n_err++;
        $display("FAIL random_overlap c=%0d got=%h exp=0", c, btn_press & btn_release);
      end
    end
    settle();
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_steady();
    test_bounce();
    test_simultaneous();
    test_autorepeat();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
